// File: rtl/sys_array_feeder_if.sv
// sys_array_feeder_if: handshake and data bus between a batch source and the systolic array feeder
// Ports: master drives start/weight_in/in_data/in_valid/in_last; slave (the feeder) drives
// in_ready, weights_load, weight_data, input_data, lane_valid, busy and done.
interface sys_array_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_A_W  = 4,
  parameter int ARRAY_W_W  = 4,
  parameter int ARRAY_W_L  = 4
);
  logic                                     start;
  logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0] weight_in;
  logic [ARRAY_A_W*DATA_WIDTH-1:0]           in_data;
  logic                                     in_valid;
  logic                                     in_last;
  logic                                     in_ready;
  logic                                     weights_load;
  logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0] weight_data;
  logic [ARRAY_A_W*DATA_WIDTH-1:0]           input_data;
  logic [ARRAY_A_W-1:0]                     lane_valid;
  logic                                     busy;
  logic                                     done;
  modport master (
    output start, weight_in, in_data, in_valid, in_last,
    input  in_ready, weights_load, weight_data, input_data, lane_valid, busy, done
  );
  modport slave (
    input  start, weight_in, in_data, in_valid, in_last,
    output in_ready, weights_load, weight_data, input_data, lane_valid, busy, done
  );
endinterface

// File: rtl/sys_array_feeder.sv
// sys_array_feeder: latches weights, pulses weights_load, then feeds activations diagonally skewed and drains
// Ports: clk, reset (sync, active-high), bus (sys_array_feeder_if.slave) carrying start/weights,
// the activation valid/ready stream in, and the skewed array feed, busy and done out.
module sys_array_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int ARRAY_A_W   = 4,
  parameter int ARRAY_W_W   = 4,
  parameter int ARRAY_W_L   = 4,
  parameter int LOAD_CYCLES = 1
) (
  input logic               clk,
  input logic               reset,
  sys_array_feeder_if.slave bus
);
  localparam int DRAIN_LEN = ARRAY_A_W - 1 + ARRAY_W_L;
  localparam int LW = LOAD_CYCLES > 1 ? $clog2(LOAD_CYCLES) : 1;
  localparam int DW = DRAIN_LEN > 1 ? $clog2(DRAIN_LEN) : 1;
  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;
  state_t r_state, w_next;
  logic [LW-1:0] r_load_cnt;
  logic [DW-1:0] r_drain_cnt;
  logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0] r_weight;
  logic w_xfer;
  logic [ARRAY_A_W*DATA_WIDTH-1:0] w_inj;
  assign w_xfer = r_state == STREAM && bus.in_valid;
  assign w_inj = w_xfer ? bus.in_data : '0;
  assign bus.weight_data = r_weight;
  always_comb begin
    w_next = r_state == IDLE   ? (bus.start ? LOAD_W : IDLE) :
             r_state == LOAD_W ? (r_load_cnt == '0 ? STREAM : LOAD_W) :
             r_state == STREAM ? (w_xfer && bus.in_last ? DRAIN : STREAM) :
                                 (r_drain_cnt == '0 ? IDLE : DRAIN);
    bus.in_ready = r_state == STREAM;
    bus.weights_load = r_state == LOAD_W;
    bus.busy = r_state != IDLE;
    bus.done = r_state == DRAIN && r_drain_cnt == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_load_cnt <= '0;
      r_drain_cnt <= '0;
      r_weight <= '0;
    end else begin
      r_state <= w_next;
      // both counters reload while outside their state, so each entry starts from the full count
      r_load_cnt <= r_state == LOAD_W ? r_load_cnt - 1'b1 : LW'(LOAD_CYCLES - 1);
      r_drain_cnt <= r_state == DRAIN ? r_drain_cnt - 1'b1 : DW'(DRAIN_LEN - 1);
      if (r_state == IDLE && bus.start) r_weight <= bus.weight_in;
    end
  end
  // lane k is a (k+1)-deep shift of {valid, data}; it shifts every cycle so bubbles carry zeros
  for (genvar k = 0; k < ARRAY_A_W; k++) begin : g_lane
    logic [DATA_WIDTH:0] r_sr [k+1];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int j = 0; j <= k; j++) r_sr[j] <= '0;
      end else begin
        r_sr[0] <= {w_xfer, w_inj[k*DATA_WIDTH +: DATA_WIDTH]};
        for (int j = 1; j <= k; j++) r_sr[j] <= r_sr[j-1];
      end
    end
    assign bus.input_data[k*DATA_WIDTH +: DATA_WIDTH] = r_sr[k][DATA_WIDTH-1:0];
    assign bus.lane_valid[k] = r_sr[k][DATA_WIDTH];
  end
endmodule

// File: doc/sys_array_feeder.md
Name: sys_array_feeder

Overview:
Upstream feeder for the weight-stationary systolic array. It latches a weight matrix and sequences the array's weights_load pulse. It then accepts activation vectors over a valid/ready handshake and presents them diagonally skewed on the array's input_data bus, so lane k enters k cycles after lane 0. After the last vector it flushes the array with zero bubbles and signals done.

Parameters:
DATA_WIDTH, 8, width of one activation/weight element
ARRAY_A_W, 4, number of input lanes (array rows fed by input_data)
ARRAY_W_W, 4, weight matrix rows
ARRAY_W_L, 4, weight matrix columns (pipeline depth used for drain)
LOAD_CYCLES, 1, cycles weights_load is held high (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse, begins a batch; honoured only in IDLE
weight_in  in  ARRAY_W_W*ARRAY_W_L*DATA_WIDTH  weight matrix, sampled on the accepted start
in_data  in  ARRAY_A_W*DATA_WIDTH  activation vector, lane 0 in LSBs
in_valid  in  1  in_data valid
in_last  in  1  marks final vector of the batch (qualified by in_valid & in_ready)
in_ready  out  1  feeder accepts a vector this cycle
weights_load  out  1  to array param_load
weight_data  out  ARRAY_W_W*ARRAY_W_L*DATA_WIDTH  registered weights to the array
input_data  out  ARRAY_A_W*DATA_WIDTH  skewed activations to the array
lane_valid  out  ARRAY_A_W  bit k set when input_data lane k carries real (non-bubble) data
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of drain

Behaviour:
- Reset: state=IDLE; all outputs 0; weight register, skew registers and counters cleared. Reset mid-batch aborts with no done pulse.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE, start=1: latch weight_in into weight_data, go to LOAD_W. Otherwise start is ignored, including in all other states.
- LOAD_W: weights_load=1 for exactly LOAD_CYCLES cycles. A counter counts LOAD_CYCLES-1 down to 0, then the FSM goes to STREAM. weight_data is stable throughout.
- STREAM:
  - in_ready=1.
  - Handshake: transfer = in_valid & in_ready.
  - Each cycle, one injection vector enters skew stage 0: on transfer it is in_data with lane-valid mask all ones; otherwise it is all zeros with mask zero (bubble).
  - Transfer with in_last=1 goes to DRAIN.
- DRAIN:
  - in_ready=0; zero bubbles injected.
  - Lasts exactly ARRAY_A_W-1+ARRAY_W_L cycles (7 at defaults).
  - On the final drain cycle, done=1 for one cycle and the FSM returns to IDLE.
  - A start arriving in the cycle done is high is ignored.
- Skew:
  - Lane k passes through k+1 registers. A vector injected at cycle t appears on input_data lane k, with lane_valid[k]=1, at cycle t+1+k.
  - Lane 0 latency is 1 cycle.
  - Skew registers shift every cycle in every state, so bubbles of zero propagate cleanly.
- busy=1 from the cycle after start is accepted until the cycle after done (i.e. state != IDLE).
- No arithmetic on data; widths are passed through unchanged.
- Counters are sized by $clog2 of the maximum count, minimum 1 bit.

Test Plan:
1. Reset then start with weight_in = 0x01..0x10 (16 bytes) -> weight_data equals weight_in next cycle; weights_load high exactly 1 cycle; in_ready rises the following cycle.
2. Stream the vector {lane3..0}={0x04,0x03,0x02,0x01} with in_last=1 at cycle t:
   - input_data lane0=0x01 at t+1, lane1=0x02 at t+2, lane2=0x03 at t+3, lane3=0x04 at t+4.
   - Each lane is 0 otherwise, and lane_valid mirrors this.
   - done pulses 7 cycles after t.
3. Stream 3 vectors with in_valid low for one cycle between vectors 1 and 2 -> the bubble appears as zero with lane_valid=0 at the matching skewed slot on every lane; in_ready stays 1 throughout STREAM.
4. LOAD_CYCLES=3 -> weights_load high for exactly 3 consecutive cycles; in_valid asserted during LOAD_W is not accepted (in_ready=0).
5. Pulse start during STREAM and again in the done cycle -> both ignored; weight_data unchanged; FSM returns to IDLE once.
6. Assert reset for one cycle mid-STREAM after 2 vectors -> next cycle all outputs 0, no done pulse, and a fresh start behaves as in scenario 1.
